// File: rtl/if_fetch_unit.sv
// if_fetch_unit: IF stage with one-outstanding SRAM-like fetch, one-entry skid buffer and redirect with stale-data discard.
// Define FETCH_ADEL_EN to deliver a misaligned PC as an if_adel entry instead of fetching it.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VEC  = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  input  logic        exc_oc,
  input  logic        eret,
  input  logic [31:0] epc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        if_id_stall,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        if_adel
);
  typedef enum logic [1:0] {IDLE, WAIT_ADDR, WAIT_DATA} state_t;
  state_t state;
  logic [31:0] pc, redirect_pc, req_pc, skid_pc, skid_inst, target, next_pc, issue_addr;
  logic discard, skid_valid, redirect, data_in, out_free, can_issue, issue;
  assign inst_wr = 1'b0;
  assign inst_size = 2'b10;
  assign inst_wdata = '0;
  assign redirect = exc_oc | eret | br_taken;
  assign target = exc_oc ? EXC_VEC : eret ? epc : br_target;
  assign next_pc = redirect ? target : pc;
  assign data_in = state == WAIT_DATA && inst_data_ok && !discard && !redirect;
  assign out_free = !if_valid || !if_id_stall;
`ifdef FETCH_ADEL_EN
  logic adel_done, adel_fire;
  assign issue_addr = next_pc;
  assign can_issue = (redirect || (!skid_valid && !(data_in && !out_free))) && next_pc[1:0] == 2'b00;
  assign adel_fire = state == IDLE && !skid_valid && pc[1:0] != 2'b00 && !adel_done;
  always_ff @(posedge clk) begin
    if (!resetn || redirect) begin
      if_adel <= 1'b0;
      adel_done <= 1'b0;
    end else if (out_free) begin
      if_adel <= adel_fire;
      if (adel_fire) adel_done <= 1'b1;
    end
  end
`else
  assign issue_addr = {next_pc[31:2], 2'b00};
  assign can_issue = redirect || (!skid_valid && !(data_in && !out_free));
  assign if_adel = 1'b0;
`endif
  // a returning word may go straight back out as the next request when the skid stays empty
  assign issue = can_issue && (state == IDLE || (state == WAIT_DATA && inst_data_ok));
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      pc <= RESET_PC;
      redirect_pc <= '0;
      req_pc <= '0;
      discard <= 1'b0;
      inst_req <= 1'b0;
      inst_addr <= '0;
    end else begin
      if (issue) begin
        state <= WAIT_ADDR;
        inst_req <= 1'b1;
        inst_addr <= issue_addr;
        req_pc <= next_pc;
      end
      case (state)
        IDLE: pc <= next_pc;
        WAIT_ADDR: begin
          if (inst_addr_ok) begin
            state <= WAIT_DATA;
            inst_req <= 1'b0;
            pc <= redirect ? target : discard ? redirect_pc : pc + 32'd4;
            discard <= discard | redirect;
          end else if (redirect) begin
            redirect_pc <= target;
            discard <= 1'b1;
          end
        end
        WAIT_DATA: begin
          pc <= next_pc;
          if (inst_data_ok) begin
            discard <= 1'b0;
            if (!issue) state <= IDLE;
          end else if (redirect) begin
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      if_valid <= 1'b0;
      if_pc <= '0;
      if_inst <= '0;
      skid_valid <= 1'b0;
      skid_pc <= '0;
      skid_inst <= '0;
    end else if (redirect) begin
      if_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_free) begin
      if (data_in) begin
        skid_valid <= 1'b1;
        skid_pc <= req_pc;
        skid_inst <= inst_rdata;
      end
    end else if (skid_valid) begin
      if_valid <= 1'b1;
      if_pc <= skid_pc;
      if_inst <= skid_inst;
      skid_valid <= 1'b0;
    end else if (data_in) begin
      if_valid <= 1'b1;
      if_pc <= req_pc;
      if_inst <= inst_rdata;
`ifdef FETCH_ADEL_EN
    end else if (adel_fire) begin
      if_valid <= 1'b1;
      if_pc <= pc;
      if_inst <= '0;
`endif
    end else begin
      if_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: randomized scoreboard bench; expected stream is program order (pc, pc+4, ...)
// restarted at the prioritized redirect target or RESET_PC, against a random-latency slave memory.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VEC = 32'hBFC0_0380;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0] inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic exc_oc, eret, br_taken, if_id_stall, if_valid, if_adel;
  logic [31:0] epc, br_target, if_pc, if_inst;
  int n_checks = 0;
  int n_fail = 0;
  int consumed = 0;
  item_t exp_q[$];
  logic [31:0] seg_pc = RESET_PC;
  logic fast = 1'b0;

  if_fetch_unit #(.RESET_PC(RESET_PC), .EXC_VEC(EXC_VEC)) dut (
    .clk(clk), .resetn(resetn), .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .exc_oc(exc_oc), .eret(eret), .epc(epc),
    .br_taken(br_taken), .br_target(br_target), .if_id_stall(if_id_stall), .if_pc(if_pc),
    .if_inst(if_inst), .if_valid(if_valid), .if_adel(if_adel)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic ok, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{seg_pc, mem({seg_pc[31:2], 2'b00})});
      seg_pc += 32'd4;
    end
  endtask

  // inputs change 2 time units after the edge; the scoreboard restarts on what the DUT just sampled
  task automatic step(input logic stall, input logic e, input logic r, input logic b, input logic rst);
    @(posedge clk);
    #2;
    if (!resetn) begin
      exp_q.delete();
      seg_pc = RESET_PC;
    end else if (exc_oc || eret || br_taken) begin
      exp_q.delete();
      if (exc_oc) seg_pc = EXC_VEC;
      else if (eret) seg_pc = epc;
      else seg_pc = br_target;
    end
    refill();
    resetn = !rst;
    if_id_stall = stall;
    exc_oc = e;
    eret = r;
    br_taken = b;
    epc = 32'h8000_0000 | ($urandom & 32'h0000_FFFC);
    br_target = 32'h9000_0000 | ($urandom & 32'h0000_FFFC);
  endtask

  task automatic rand_step();
    step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2,
         $urandom_range(0, 99) < 3, 1'b0);
  endtask

  // slave memory: random addr/data latency, stray data_ok, and a stale data_ok after a reset
  initial begin
    logic pend, stale, rst_d;
    logic [31:0] pend_addr, acc_addr;
    pend = 0; stale = 0; rst_d = 0; pend_addr = 0; acc_addr = 0;
    inst_addr_ok = 0; inst_data_ok = 0; inst_rdata = 0;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        stale = stale | pend | inst_addr_ok;
        pend = 0;
      end else begin
        if (inst_data_ok) pend = 0;
        if (inst_addr_ok) begin
          check("one_outstanding", !pend, {31'd0, pend}, 32'd0);
          pend = 1;
          pend_addr = acc_addr;
        end
      end
      #1;
      if (resetn && !rst_d && stale) begin
        inst_addr_ok = 0;
        inst_data_ok = 1;
        inst_rdata = $urandom;
        stale = 0;
      end else begin
        inst_addr_ok = resetn && inst_req && (fast || $urandom_range(0, 99) < 60);
        acc_addr = inst_addr;
        inst_data_ok = resetn && (pend ? (fast || $urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 3));
        inst_rdata = (pend && inst_data_ok) ? mem(pend_addr) : $urandom;
      end
      rst_d = resetn;
    end
  end

  // monitor: scoreboard pops on every ID consumption, plus request/stall hold checks
  initial begin
    logic live_d, v_d, s_d, red_d, q_d, aok_d;
    logic [31:0] pc_d, inst_d, a_d;
    item_t e;
    live_d = 0; v_d = 0; s_d = 0; red_d = 0; q_d = 0; aok_d = 0; pc_d = 0; inst_d = 0; a_d = 0;
    forever begin
      @(negedge clk);
      if (live_d) begin
        if (q_d && !aok_d) begin
          check("req_held", inst_req, {31'd0, inst_req}, 32'd1);
          check("addr_held", inst_addr == a_d, inst_addr, a_d);
        end
        if (v_d && s_d && !red_d) begin
          check("stall_valid", if_valid, {31'd0, if_valid}, 32'd1);
          check("stall_pc", if_pc == pc_d, if_pc, pc_d);
          check("stall_inst", if_inst == inst_d, if_inst, inst_d);
        end
      end
      if (resetn && if_valid && !if_id_stall) begin
        consumed++;
        if (exp_q.size() == 0) begin
          check("unexpected_delivery", 1'b0, if_pc, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("deliver_pc", if_pc == e.pc, if_pc, e.pc);
          check("deliver_inst", if_inst == e.inst, if_inst, e.inst);
          check("deliver_adel", !if_adel, {31'd0, if_adel}, 32'd0);
        end
      end
      live_d = resetn; v_d = if_valid; s_d = if_id_stall; red_d = exc_oc | eret | br_taken;
      q_d = inst_req; aok_d = inst_addr_ok; pc_d = if_pc; inst_d = if_inst; a_d = inst_addr;
    end
  end

  initial begin
    int c0, n;
    exc_oc = 0; eret = 0; br_taken = 0; epc = 0; br_target = 0; if_id_stall = 0;
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("rst_req", !inst_req, {31'd0, inst_req}, 32'd0);
    check("rst_addr", inst_addr == 32'd0, inst_addr, 32'd0);
    check("rst_valid", !if_valid, {31'd0, if_valid}, 32'd0);
    check("rst_pc", if_pc == 32'd0, if_pc, 32'd0);
    check("rst_inst", if_inst == 32'd0, if_inst, 32'd0);
    check("rst_adel", !if_adel, {31'd0, if_adel}, 32'd0);
    check("tie_wr", !inst_wr, {31'd0, inst_wr}, 32'd0);
    check("tie_size", inst_size == 2'b10, {30'd0, inst_size}, 32'd2);
    check("tie_wdata", inst_wdata == 32'd0, inst_wdata, 32'd0);
    fast = 1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("first_req", inst_req, {31'd0, inst_req}, 32'd1);
    check("first_addr", inst_addr == RESET_PC, inst_addr, RESET_PC);
    c0 = consumed;
    repeat (100) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("zero_wait_rate", consumed - c0 >= 45, consumed - c0, 32'd45);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    fast = 0;
    repeat (3000) rand_step();
    n = 0;
    while (!(inst_req && inst_addr_ok) && n < 200) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    check("await_accept", n < 200, n, 32'd200);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("midrst_req", !inst_req, {31'd0, inst_req}, 32'd0);
    check("midrst_valid", !if_valid, {31'd0, if_valid}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (400) rand_step();
    repeat (30) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("liveness", consumed >= 200, consumed, 32'd200);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
